axi4lite_regbank: RTL
=====================

// Module: axi4lite_regbank
// PURPOSE
//  Parametrised AXI4-Lite slave register bank; successor to the fixed 4-register FMC controller slave.
//  Provides NUM_RW read/write control registers with byte strobes and per-register write pulses,
//  plus NUM_RO read-only status registers sampled from fabric. Sits behind the AXI interconnect/VIP master.
//  Out-of-range or read-only-targeted writes return SLVERR; out-of-range reads return SLVERR and 0.
// PARAMETERS
//  DATA_WIDTH  32  AXI data width (32 or 64); STRB width = DATA_WIDTH/8
//  ADDR_WIDTH  6   AXI byte address width; word index = addr[ADDR_WIDTH-1:log2(DATA_WIDTH/8)]
//  NUM_RW      8   control registers at word index 0..NUM_RW-1 (>=1)
//  NUM_RO      4   status registers at word index NUM_RW..NUM_RW+NUM_RO-1 (>=0)
//  RST_VAL     0   reset value of every RW register (DATA_WIDTH bits)
// PORTS
//  S_AXI_ACLK     in   1               clock
//  S_AXI_ARESETN  in   1               asynchronous active-low reset
//  S_AXI_AWADDR   in   ADDR_WIDTH      write address;  S_AXI_AWPROT in 3 ignored
//  S_AXI_AWVALID  in   1  / S_AXI_AWREADY out 1   write address handshake
//  S_AXI_WDATA    in   DATA_WIDTH      write data;     S_AXI_WSTRB in DATA_WIDTH/8 byte enables
//  S_AXI_WVALID   in   1  / S_AXI_WREADY  out 1   write data handshake
//  S_AXI_BRESP    out  2               00 OKAY, 10 SLVERR
//  S_AXI_BVALID   out  1  / S_AXI_BREADY  in  1   write response handshake
//  S_AXI_ARADDR   in   ADDR_WIDTH      read address;   S_AXI_ARPROT in 3 ignored
//  S_AXI_ARVALID  in   1  / S_AXI_ARREADY out 1   read address handshake
//  S_AXI_RDATA    out  DATA_WIDTH      read data;      S_AXI_RRESP out 2
//  S_AXI_RVALID   out  1  / S_AXI_RREADY  in  1   read data handshake
//  ctrl_o         out  NUM_RW*DATA_WIDTH   RW register contents, reg k at [k*DW +: DW]
//  wr_pulse_o     out  NUM_RW          1-cycle pulse on bit k when reg k is written
//  status_i       in   NUM_RO*DATA_WIDTH   RO register sources, sampled at AR handshake
// BEHAVIOUR
//  Reset (async assert, sync-to-clock deassert by upstream): AWREADY=WREADY=ARREADY=0 during reset,
//   1 from first cycle after release; BVALID=RVALID=0; BRESP=RRESP=00; RDATA=0; ctrl_o=RST_VAL; wr_pulse_o=0.
//  Write FSM: W_IDLE -> (AW only) W_WAITW | (W only) W_WAITA | (both) commit -> W_RESP.
//   W_IDLE: AWREADY=WREADY=1. W_WAITW: AWREADY=0,WREADY=1. W_WAITA: AWREADY=1,WREADY=0.
//   Captured channel held until partner arrives; order of AW vs W is free.
//   Commit in cycle both are captured: reg updated per WSTRB at that edge, wr_pulse_o[k]=1 next cycle
//   for exactly one cycle, BVALID=1 next cycle. W_RESP: all write readies 0, BVALID held until BREADY.
//   BVALID&BREADY -> W_IDLE; new AW/W accepted the following cycle (one outstanding write).
//   WSTRB=0 to RW reg: no data change, pulse still fires, BRESP=OKAY.
//   Index in RO range or >= NUM_RW+NUM_RO: no update, no pulse, BRESP=SLVERR.
//  Read FSM: R_IDLE (ARREADY=1) -> AR handshake in cycle N -> R_DATA, RVALID=1 in N+1 with RDATA/RRESP;
//   held stable until RREADY; RVALID&RREADY -> R_IDLE, ARREADY=1 next cycle (one outstanding read).
//   RW index: ctrl value; RO index: status_i slice registered at AR handshake; else RDATA=0, RRESP=SLVERR.
//  Simultaneous read and write commit to same reg in one cycle: read returns pre-write value.
//  Read and write FSMs independent; both may be active concurrently.
//  Low address bits below word alignment ignored; unaligned addresses map to containing word.
//  Reset mid-transaction: FSMs to idle, pending response dropped, registers to RST_VAL.
// TESTING
//  1 Write 0x1,0x2,0x3,0x4 to addr 0x0..0xC (AW,W same cycle), read back -> 0x1..0x4, OKAY; BVALID 1 cycle after handshake.
//  2 W leads AW by 3 cycles, WDATA=0xDEADBEEF to 0x8 -> WREADY drops after W, commit on AW, wr_pulse_o[2] one cycle, read 0xDEADBEEF.
//  3 Reg1=0x11223344, write 0xAABBCCDD WSTRB=0b0101 -> reg1 reads 0x11BB33DD.
//  4 status_i slice 0=0xCAFE0001, read addr NUM_RW*4 -> 0xCAFE0001 OKAY; write there -> SLVERR, no pulse, read unchanged.
//  5 Read addr (NUM_RW+NUM_RO)*4 -> RDATA=0 SLVERR; BREADY/RREADY held low 5 cycles -> BVALID/RVALID and data stable, readies 0.
//  6 Assert ARESETN=0 while BVALID pending -> BVALID=0 immediately, ctrl_o=RST_VAL, readies 1 one cycle after release.

Source files
------------

// File: rtl/axi4lite_regbank.sv
// rtl/axi4lite_regbank.sv - AXI4-Lite slave with RW control registers and sampled RO status registers
module axi4lite_regbank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_RW     = 8,
    parameter int NUM_RO     = 4,
    parameter logic [DATA_WIDTH-1:0] RST_VAL = '0
) (
    input  logic                         S_AXI_ACLK,
    input  logic                         S_AXI_ARESETN,
    input  logic [ADDR_WIDTH-1:0]        S_AXI_AWADDR,
    input  logic [2:0]                   S_AXI_AWPROT,
    input  logic                         S_AXI_AWVALID,
    output logic                         S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]        S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]      S_AXI_WSTRB,
    input  logic                         S_AXI_WVALID,
    output logic                         S_AXI_WREADY,
    output logic [1:0]                   S_AXI_BRESP,
    output logic                         S_AXI_BVALID,
    input  logic                         S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]        S_AXI_ARADDR,
    input  logic [2:0]                   S_AXI_ARPROT,
    input  logic                         S_AXI_ARVALID,
    output logic                         S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]        S_AXI_RDATA,
    output logic [1:0]                   S_AXI_RRESP,
    output logic                         S_AXI_RVALID,
    input  logic                         S_AXI_RREADY,
    output logic [NUM_RW*DATA_WIDTH-1:0] ctrl_o,
    output logic [NUM_RW-1:0]            wr_pulse_o,
    input  logic [NUM_RO*DATA_WIDTH-1:0] status_i
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int AL     = $clog2(STRB_W);
    localparam int IW     = ADDR_WIDTH - AL;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_WAITW, W_WAITA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    logic clk;
    logic rst_n;
    assign clk   = S_AXI_ACLK;
    assign rst_n = S_AXI_ARESETN;

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[AL-1:0], S_AXI_ARADDR[AL-1:0]};

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    // Holds readies low until the first edge after reset release.
    logic rdy_en;

    logic [DATA_WIDTH-1:0] ctrl_q [NUM_RW];
    logic [IW-1:0]         awidx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic [1:0]            bresp_q;
    logic [NUM_RW-1:0]     wr_pulse_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            rresp_q;

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [IW-1:0]         c_widx;
    logic [DATA_WIDTH-1:0] c_data;
    logic [STRB_W-1:0]     c_strb;
    logic                  c_rw;
    logic [IW-1:0]         r_widx;
    logic [DATA_WIDTH-1:0] rd_data_d;
    logic [1:0]            rd_resp_d;

    assign S_AXI_AWREADY = rdy_en && (w_state == W_IDLE || w_state == W_WAITA);
    assign S_AXI_WREADY  = rdy_en && (w_state == W_IDLE || w_state == W_WAITW);
    assign S_AXI_BVALID  = (w_state == W_RESP);
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = rdy_en && (r_state == R_IDLE);
    assign S_AXI_RVALID  = (r_state == R_DATA);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign wr_pulse_o    = wr_pulse_q;

    genvar g;
    generate
        for (g = 0; g < NUM_RW; g++) begin : g_ctrl
            assign ctrl_o[g*DATA_WIDTH +: DATA_WIDTH] = ctrl_q[g];
        end
    endgenerate

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // A channel captured earlier is used; otherwise the live bus value commits directly.
    assign c_widx = (w_state == W_WAITW) ? awidx_q : S_AXI_AWADDR[ADDR_WIDTH-1:AL];
    assign c_data = (w_state == W_WAITA) ? wdata_q : S_AXI_WDATA;
    assign c_strb = (w_state == W_WAITA) ? wstrb_q : S_AXI_WSTRB;
    assign c_rw   = int'(c_widx) < NUM_RW;
    assign r_widx = S_AXI_ARADDR[ADDR_WIDTH-1:AL];

    always_comb begin
        w_next = w_state;
        commit = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end else if (aw_hs) begin
                    w_next = W_WAITW;
                end else if (w_hs) begin
                    w_next = W_WAITA;
                end
            end
            W_WAITW: begin
                if (w_hs) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end
            end
            W_WAITA: begin
                if (aw_hs) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state    <= W_IDLE;
            rdy_en     <= 1'b0;
            awidx_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            for (int k = 0; k < NUM_RW; k++) ctrl_q[k] <= RST_VAL;
        end else begin
            rdy_en     <= 1'b1;
            w_state    <= w_next;
            wr_pulse_q <= '0;
            if (aw_hs) awidx_q <= S_AXI_AWADDR[ADDR_WIDTH-1:AL];
            if (w_hs) begin
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (commit) begin
                bresp_q <= c_rw ? RESP_OKAY : RESP_SLVERR;
                for (int k = 0; k < NUM_RW; k++) begin
                    if (c_rw && int'(c_widx) == k) begin
                        wr_pulse_q[k] <= 1'b1;
                        for (int b = 0; b < STRB_W; b++) begin
                            if (c_strb[b]) ctrl_q[k][b*8 +: 8] <= c_data[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        rd_data_d = '0;
        rd_resp_d = RESP_SLVERR;
        for (int k = 0; k < NUM_RW; k++) begin
            if (int'(r_widx) == k) begin
                rd_data_d = ctrl_q[k];
                rd_resp_d = RESP_OKAY;
            end
        end
        for (int k = 0; k < NUM_RO; k++) begin
            if (int'(r_widx) == NUM_RW + k) begin
                rd_data_d = status_i[k*DATA_WIDTH +: DATA_WIDTH];
                rd_resp_d = RESP_OKAY;
            end
        end
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (S_AXI_RREADY) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Read data samples the pre-edge register value, so a same-cycle write is not visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                rdata_q <= rd_data_d;
                rresp_q <= rd_resp_d;
            end
        end
    end
endmodule
